cpu_bus_timer: RTL and testbench



---
 rtl/cpu_bus_timer.sv | 133 +++++++++++++
 tb/tb_cpu_bus_timer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_timer.sv
// Memory-mapped 16-bit reloadable down-counter with 8-bit prescaler and irq/nmi routing.
// Optional macro CPU_BUS_TIMER_WAIT_EN inserts one wait state on every selected access.
module cpu_bus_timer #(
   parameter logic [15:0] BASE = 16'hD000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic        write,
   input  logic [7:0]  data_i,
   output logic [7:0]  data_o,
   output logic        ready,
   output logic        irq,
   output logic        nmi
);

   localparam logic [2:0] REG_CNT_LO   = 3'd0;
   localparam logic [2:0] REG_CNT_HI   = 3'd1;
   localparam logic [2:0] REG_LAT_LO   = 3'd2;
   localparam logic [2:0] REG_LAT_HI   = 3'd3;
   localparam logic [2:0] REG_CTRL     = 3'd4;
   localparam logic [2:0] REG_STATUS   = 3'd5;
   localparam logic [2:0] REG_PRESCALE = 3'd6;

   logic [15:0] latch;
   logic [15:0] counter;
   logic [3:0]  ctrl;
   logic [7:0]  prescale;
   logic [7:0]  pcnt;
   logic        tf;

   logic        sel;
   logic [2:0]  idx;
   logic        wr_en;
   logic        rd_en;
   logic        tick;
   logic [7:0]  rdata;

   assign sel   = (address[15:3] == BASE[15:3]);
   assign idx   = address[2:0];
   assign wr_en = sel & ready & write;
   assign rd_en = sel & ready & ~write;
   assign tick  = ctrl[0] & (pcnt == 8'd0);

`ifdef CPU_BUS_TIMER_WAIT_EN
   // First cycle of a selected access stalls; the second completes and re-arms for the next access.
   logic waited;

   always_ff @(posedge clk) begin
      if (reset) begin
         waited <= 1'b0;
      end else begin
         waited <= sel & ~waited;
      end
   end

   assign ready = ~sel | waited;
`else
   assign ready = 1'b1;
`endif

   assign irq = tf & ctrl[2] & ~ctrl[3];
   assign nmi = tf & ctrl[2] & ctrl[3];

   always_comb begin
      rdata = 8'h00;
      case (idx)
         REG_CNT_LO:   rdata = counter[7:0];
         REG_CNT_HI:   rdata = counter[15:8];
         REG_LAT_LO:   rdata = latch[7:0];
         REG_LAT_HI:   rdata = latch[15:8];
         REG_CTRL:     rdata = {4'h0, ctrl};
         REG_STATUS:   rdata = {irq | nmi, 6'b000000, tf};
         REG_PRESCALE: rdata = prescale;
         default:      rdata = 8'h00;
      endcase
      data_o = (sel & ~write) ? rdata : 8'h00;
   end

   // Later assignments win: status clears, then the underflow set, then bus writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         latch    <= 16'hFFFF;
         counter  <= 16'hFFFF;
         ctrl     <= 4'h0;
         prescale <= 8'h00;
         pcnt     <= 8'h00;
         tf       <= 1'b0;
      end else begin
         if (ctrl[0]) begin
            pcnt <= (pcnt == 8'd0) ? prescale : pcnt - 8'd1;
         end

         if (rd_en && idx == REG_STATUS) begin
            tf <= 1'b0;
         end
         if (wr_en && idx == REG_STATUS && data_i[0]) begin
            tf <= 1'b0;
         end

         if (tick) begin
            if (counter != 16'd0) begin
               counter <= counter - 16'd1;
            end else begin
               tf <= 1'b1;
               if (ctrl[1]) begin
                  counter <= latch;
               end else begin
                  ctrl[0] <= 1'b0;
               end
            end
         end

         if (wr_en) begin
            case (idx)
               REG_CNT_LO: latch[7:0] <= data_i;
               REG_CNT_HI: begin
                  latch[15:8] <= data_i;
                  counter     <= {data_i, latch[7:0]};
                  pcnt        <= prescale;
                  tf          <= 1'b0;
               end
               REG_LAT_LO:   latch[7:0]  <= data_i;
               REG_LAT_HI:   latch[15:8] <= data_i;
               REG_CTRL:     ctrl        <= data_i[3:0];
               REG_PRESCALE: prescale    <= data_i;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cpu_bus_timer.sv
// Directed self-checking bench for cpu_bus_timer; cycle-exact timer tests run in the zero-wait build,
// the wait-state test runs when CPU_BUS_TIMER_WAIT_EN is defined.
module tb_cpu_bus_timer;

   localparam logic [15:0] BASE = 16'hD000;
   localparam logic [15:0] IDLE = 16'h0000;

   logic        clk;
   logic        reset;
   logic [15:0] address;
   logic        write;
   logic [7:0]  data_i;
   logic [7:0]  data_o;
   logic        ready;
   logic        irq;
   logic        nmi;

   int checks;
   int failures;

   cpu_bus_timer #(.BASE(BASE)) dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .write(write),
      .data_i(data_i),
      .data_o(data_o),
      .ready(ready),
      .irq(irq),
      .nmi(nmi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one access and return one time unit after the edge at which it completes.
   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      int n;
      n = 0;
      address = a;
      write   = 1'b1;
      data_i  = d;
      @(negedge clk);
      while (ready !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (ready !== 1'b1) begin
         checks++;
         failures++;
         $display("[TB] FAIL bus_write_timeout ready=%b required=1", ready);
      end
      @(posedge clk);
      #1;
      address = IDLE;
      write   = 1'b0;
      data_i  = 8'h00;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
      int n;
      n = 0;
      address = a;
      write   = 1'b0;
      data_i  = 8'h00;
      @(negedge clk);
      while (ready !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (ready !== 1'b1) begin
         checks++;
         failures++;
         $display("[TB] FAIL bus_read_timeout ready=%b required=1", ready);
      end
      d = data_o;
      @(posedge clk);
      #1;
      address = IDLE;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [7:0] d;
      logic [7:0] e;
      reset   = 1'b1;
      address = IDLE;
      write   = 1'b0;
      data_i  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b required=1", ready); end
      checks++;
      if (irq !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq got=%b required=0", irq); end
      checks++;
      if (nmi !== 1'b0) begin failures++; $display("[TB] FAIL reset_nmi got=%b required=0", nmi); end
      checks++;
      if (data_o !== 8'h00) begin failures++; $display("[TB] FAIL reset_data_o got=%h required=00", data_o); end
      for (int i = 0; i < 8; i++) begin
         bus_read(BASE + 16'(i), d);
         e = (i < 4) ? 8'hFF : 8'h00;
         checks++;
         if (d !== e) begin failures++; $display("[TB] FAIL reset_reg%0d got=%h required=%h", i, d, e); end
      end
   endtask

   task automatic test_decode;
      logic [7:0] d;
      bus_write(BASE + 16'd12, 8'h07);
      bus_read(BASE + 16'd4, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("[TB] FAIL decode_outside_write got=%h required=00", d); end
      bus_read(BASE + 16'd8, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("[TB] FAIL decode_outside_read got=%h required=00", d); end
      bus_write(BASE + 16'd7, 8'hA5);
      bus_read(BASE + 16'd7, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("[TB] FAIL decode_reg7 got=%h required=00", d); end
      bus_write(BASE + 16'd4, 8'hF0);
      bus_read(BASE + 16'd4, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("[TB] FAIL decode_ctrl_upper got=%h required=00", d); end
      bus_write(BASE + 16'd3, 8'h5A);
      bus_read(BASE + 16'd3, d);
      checks++;
      if (d !== 8'h5A) begin failures++; $display("[TB] FAIL decode_lat_hi got=%h required=5a", d); end
      bus_read(BASE + 16'd1, d);
      checks++;
      if (d !== 8'hFF) begin failures++; $display("[TB] FAIL decode_cnt_hi_untouched got=%h required=ff", d); end
   endtask

   task automatic test_continuous;
      logic [7:0] d;
      bus_write(BASE + 16'd4, 8'h00);
      bus_write(BASE + 16'd6, 8'h00);
      bus_write(BASE + 16'd2, 8'h03);
      bus_write(BASE + 16'd1, 8'h00);
      bus_write(BASE + 16'd4, 8'h07);
      for (int i = 0; i < 4; i++) begin
         bus_read(BASE, d);
         checks++;
         if (d !== 8'(3 - i)) begin failures++; $display("[TB] FAIL cont_count%0d got=%h required=%h", i, d, 8'(3 - i)); end
      end
      bus_read(BASE, d);
      checks++;
      if (d !== 8'h03) begin failures++; $display("[TB] FAIL cont_reload got=%h required=03", d); end
      checks++;
      if (irq !== 1'b1) begin failures++; $display("[TB] FAIL cont_irq_set got=%b required=1", irq); end
      bus_write(BASE + 16'd5, 8'h01);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("[TB] FAIL cont_irq_clear got=%b required=0", irq); end
      idle(1);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("[TB] FAIL cont_irq_early got=%b required=0", irq); end
      idle(1);
      checks++;
      if (irq !== 1'b1) begin failures++; $display("[TB] FAIL cont_period4 got=%b required=1", irq); end
   endtask

   task automatic test_one_shot;
      logic [7:0] d;
      bus_write(BASE + 16'd4, 8'h00);
      bus_write(BASE + 16'd6, 8'h00);
      bus_write(BASE + 16'd2, 8'h02);
      bus_write(BASE + 16'd1, 8'h00);
      bus_write(BASE + 16'd4, 8'h05);
      idle(6);
      checks++;
      if (irq !== 1'b1) begin failures++; $display("[TB] FAIL oneshot_irq got=%b required=1", irq); end
      bus_read(BASE + 16'd4, d);
      checks++;
      if (d !== 8'h04) begin failures++; $display("[TB] FAIL oneshot_run_cleared got=%h required=04", d); end
      bus_read(BASE + 16'd0, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("[TB] FAIL oneshot_cnt_lo got=%h required=00", d); end
      bus_read(BASE + 16'd1, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("[TB] FAIL oneshot_cnt_hi got=%h required=00", d); end
      bus_read(BASE + 16'd5, d);
      checks++;
      if (d !== 8'h81) begin failures++; $display("[TB] FAIL oneshot_status got=%h required=81", d); end
      bus_read(BASE + 16'd5, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("[TB] FAIL oneshot_status_cleared got=%h required=00", d); end
      checks++;
      if (irq !== 1'b0) begin failures++; $display("[TB] FAIL oneshot_irq_cleared got=%b required=0", irq); end
   endtask

   task automatic test_prescale_nmi;
      logic [7:0] d;
      bus_write(BASE + 16'd4, 8'h00);
      bus_write(BASE + 16'd6, 8'h02);
      bus_write(BASE + 16'd2, 8'h01);
      bus_write(BASE + 16'd1, 8'h00);
      bus_write(BASE + 16'd4, 8'h07);
      idle(5);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("[TB] FAIL pre_irq_early got=%b required=0", irq); end
      idle(1);
      checks++;
      if (irq !== 1'b1) begin failures++; $display("[TB] FAIL pre_first_underflow got=%b required=1", irq); end
      bus_write(BASE + 16'd5, 8'h01);
      idle(4);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("[TB] FAIL pre_irq_between got=%b required=0", irq); end
      idle(1);
      checks++;
      if (irq !== 1'b1) begin failures++; $display("[TB] FAIL pre_period6 got=%b required=1", irq); end
      bus_write(BASE + 16'd4, 8'h0F);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("[TB] FAIL nsel_irq got=%b required=0", irq); end
      checks++;
      if (nmi !== 1'b1) begin failures++; $display("[TB] FAIL nsel_nmi got=%b required=1", nmi); end
      bus_read(BASE + 16'd5, d);
      checks++;
      if (d !== 8'h81) begin failures++; $display("[TB] FAIL nsel_status got=%h required=81", d); end
      checks++;
      if (nmi !== 1'b0) begin failures++; $display("[TB] FAIL nsel_nmi_cleared got=%b required=0", nmi); end
   endtask

   task automatic test_simultaneous;
      logic [7:0] d;
      bus_write(BASE + 16'd4, 8'h00);
      bus_write(BASE + 16'd6, 8'h02);
      bus_write(BASE + 16'd2, 8'h01);
      bus_write(BASE + 16'd1, 8'h00);
      bus_write(BASE + 16'd4, 8'h07);
      idle(5);
      bus_read(BASE + 16'd5, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("[TB] FAIL sim_status_before got=%h required=00", d); end
      checks++;
      if (irq !== 1'b1) begin failures++; $display("[TB] FAIL sim_set_wins got=%b required=1", irq); end
      bus_write(BASE + 16'd5, 8'h01);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("[TB] FAIL sim_write_clear got=%b required=0", irq); end
      idle(4);
      bus_write(BASE + 16'd1, 8'h00);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("[TB] FAIL sim_cnthi_wins_tf got=%b required=0", irq); end
      bus_read(BASE, d);
      checks++;
      if (d !== 8'h01) begin failures++; $display("[TB] FAIL sim_cnthi_counter got=%h required=01", d); end
      idle(4);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("[TB] FAIL sim_cnthi_early got=%b required=0", irq); end
      idle(1);
      checks++;
      if (irq !== 1'b1) begin failures++; $display("[TB] FAIL sim_cnthi_restart got=%b required=1", irq); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] d;
      bus_write(BASE + 16'd4, 8'h00);
      bus_write(BASE + 16'd6, 8'h00);
      bus_write(BASE + 16'd2, 8'h00);
      bus_write(BASE + 16'd1, 8'h00);
      bus_write(BASE + 16'd4, 8'h07);
      idle(2);
      checks++;
      if (irq !== 1'b1) begin failures++; $display("[TB] FAIL rmid_irq_before got=%b required=1", irq); end
      bus_write(BASE + 16'd6, 8'h05);
      reset   = 1'b1;
      address = BASE + 16'd4;
      write   = 1'b1;
      data_i  = 8'h0F;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      address = IDLE;
      write   = 1'b0;
      data_i  = 8'h00;
      checks++;
      if (irq !== 1'b0) begin failures++; $display("[TB] FAIL rmid_irq got=%b required=0", irq); end
      checks++;
      if (ready !== 1'b1) begin failures++; $display("[TB] FAIL rmid_ready got=%b required=1", ready); end
      bus_read(BASE + 16'd4, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("[TB] FAIL rmid_ctrl got=%h required=00", d); end
      bus_read(BASE + 16'd6, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("[TB] FAIL rmid_prescale got=%h required=00", d); end
      bus_read(BASE + 16'd1, d);
      checks++;
      if (d !== 8'hFF) begin failures++; $display("[TB] FAIL rmid_cnt_hi got=%h required=ff", d); end
      bus_read(BASE + 16'd2, d);
      checks++;
      if (d !== 8'hFF) begin failures++; $display("[TB] FAIL rmid_lat_lo got=%h required=ff", d); end
   endtask

`ifdef CPU_BUS_TIMER_WAIT_EN
   task automatic test_wait_state;
      logic [7:0] d;
      address = BASE + 16'd4;
      write   = 1'b1;
      data_i  = 8'h05;
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin failures++; $display("[TB] FAIL wait_first_cycle got=%b required=0", ready); end
      @(posedge clk);
      #1;
      write  = 1'b0;
      data_i = 8'h00;
      @(negedge clk);
      checks++;
      if (ready !== 1'b1) begin failures++; $display("[TB] FAIL wait_second_cycle got=%b required=1", ready); end
      checks++;
      if (data_o !== 8'h00) begin failures++; $display("[TB] FAIL wait_no_early_commit got=%h required=00", data_o); end
      @(posedge clk);
      #1;
      address = IDLE;
      bus_write(BASE + 16'd4, 8'h05);
      bus_read(BASE + 16'd4, d);
      checks++;
      if (d !== 8'h05) begin failures++; $display("[TB] FAIL wait_ctrl_written got=%h required=05", d); end
      address = BASE + 16'd6;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (ready !== 1'b1) begin failures++; $display("[TB] FAIL wait_b2b_first_done got=%b required=1", ready); end
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin failures++; $display("[TB] FAIL wait_b2b_second_wait got=%b required=0", ready); end
      @(posedge clk);
      #1;
      address = BASE + 16'd4;
      write   = 1'b1;
      data_i  = 8'h0F;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      address = IDLE;
      write   = 1'b0;
      data_i  = 8'h00;
      checks++;
      if (ready !== 1'b1) begin failures++; $display("[TB] FAIL wait_reset_ready got=%b required=1", ready); end
      bus_read(BASE + 16'd4, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("[TB] FAIL wait_reset_ctrl got=%h required=00", d); end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      address  = IDLE;
      write    = 1'b0;
      data_i   = 8'h00;
      test_reset;
      test_decode;
`ifndef CPU_BUS_TIMER_WAIT_EN
      test_continuous;
`endif
      test_one_shot;
`ifndef CPU_BUS_TIMER_WAIT_EN
      test_prescale_nmi;
      test_simultaneous;
`endif
      test_reset_mid;
`ifdef CPU_BUS_TIMER_WAIT_EN
      test_wait_state;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
